// File: rtl/sdram_device_responder_pkg.sv
// Shared encodings for the SDR SDRAM device responder: commands, error codes,
// bank and init states, plus the command decoder and saturating counters.
package sdram_device_responder_pkg;

  typedef enum logic [2:0] {
    CmdNop, CmdRead, CmdWrite, CmdAct, CmdPre, CmdRef, CmdMrs, CmdBst
  } cmd_e;

  typedef enum logic [1:0] {BankIdle, BankActive, BankPrechg} bank_st_e;

  typedef enum logic [1:0] {InitWaitPre, InitWaitRef, InitWaitMrs, InitReady} init_st_e;

  localparam logic [3:0] ErrNone    = 4'd0;
  localparam logic [3:0] ErrPreInit = 4'd1;
  localparam logic [3:0] ErrTrcd    = 4'd2;
  localparam logic [3:0] ErrTrp     = 4'd3;
  localparam logic [3:0] ErrActOpen = 4'd4;
  localparam logic [3:0] ErrNotOpen = 4'd5;
  localparam logic [3:0] ErrTrcMrd  = 4'd6;
  localparam logic [3:0] ErrRefLate = 4'd7;
  localparam logic [3:0] ErrMode    = 4'd8;
  localparam logic [3:0] ErrNotIdle = 4'd9;

  // pins = {cs_n, ras_n, cas_n, we_n}; a disabled clock or deselected chip is a NOP
  function automatic cmd_e decode_cmd(input logic clken, input logic [3:0] pins);
    cmd_e c;
    if (!clken || pins[3]) begin
      c = CmdNop;
    end else begin
      case (pins[2:0])
        3'b101:  c = CmdRead;
        3'b100:  c = CmdWrite;
        3'b011:  c = CmdAct;
        3'b010:  c = CmdPre;
        3'b001:  c = CmdRef;
        3'b000:  c = CmdMrs;
        3'b110:  c = CmdBst;
        default: c = CmdNop;
      endcase
    end
    return c;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Word store for the responder: synchronous byte-enabled write, registered read port.
module sdram_resp_mem #(
  parameter int unsigned Aw = 13
) (
  input  logic          clk_i,
  input  logic [Aw-1:0] addr_i,
  input  logic          we_i,
  input  logic [1:0]    be_i,
  input  logic [15:0]   wdata_i,
  input  logic          re_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [2**Aw];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/sdram_device_responder.sv
// SDR SDRAM device model: command decode, init sequencing, per-bank row state with
// timing checks, CAS-latency read pipeline and sticky first-error reporting.
module sdram_device_responder
  import sdram_device_responder_pkg::*;
#(
  parameter int unsigned MEM_AW    = 13,
  parameter int unsigned T_RCD     = 2,
  parameter int unsigned T_RP      = 2,
  parameter int unsigned T_RC      = 8,
  parameter int unsigned T_MRD     = 2,
  parameter int unsigned T_REF_MAX = 390,
  parameter int unsigned INIT_REFS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_cs_n,
  input  logic        s_ras_n,
  input  logic        s_cas_n,
  input  logic        s_wr_en,
  input  logic        s_clken,
  input  logic [1:0]  s_bytesel,
  input  logic [12:0] s_addr,
  input  logic [1:0]  s_banksel,
  input  logic [15:0] s_dq_in,
  output logic [15:0] s_dq_out,
  output logic [1:0]  s_dq_oe,
  output logic        init_done,
  output logic        err,
  output logic [3:0]  err_code
);

  localparam logic [7:0]  TRcd     = 8'(T_RCD);
  localparam logic [7:0]  TRp      = 8'(T_RP);
  localparam logic [7:0]  TRc      = 8'(T_RC);
  localparam logic [7:0]  TMrd     = 8'(T_MRD);
  localparam logic [15:0] TRefMax  = 16'(T_REF_MAX);
  localparam logic [7:0]  InitRefs = 8'(INIT_REFS);

  cmd_e        cmd;
  bank_st_e    bank_q [4], bank_d [4], bank_eff [4];
  logic [12:0] row_q [4], row_d [4];
  logic [7:0]  tmr_q [4], tmr_d [4];
  init_st_e    init_q, init_d;
  logic [7:0]  init_refs_q, init_refs_d;
  logic        cl3_q, cl3_d;
  logic [7:0]  rc_q, rc_d, mrd_q, mrd_d;
  logic [15:0] ref_age_q, ref_age_d;
  logic        err_q, err_d;
  logic [3:0]  code_q, code_d, code_now;
  logic [1:0]  rd_oe_q;
  logic [15:0] pipe_data_q [2];
  logic [1:0]  pipe_oe_q [2];
  logic [15:0] mem_rdata, out_data;
  logic [1:0]  out_oe;
  logic        all_idle, is_rw, sel_active, access_ok, mode_ok, rd_en, wr_en;
  logic [MEM_AW-1:0] mem_addr;

  assign cmd = decode_cmd(s_clken, {s_cs_n, s_ras_n, s_cas_n, s_wr_en});

  // A precharging bank whose tRP has elapsed is treated as idle from that edge on
  always_comb begin
    all_idle = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bank_eff[b] = bank_q[b];
      if (bank_q[b] == BankPrechg && tmr_q[b] >= TRp) bank_eff[b] = BankIdle;
      if (bank_eff[b] != BankIdle) all_idle = 1'b0;
    end
  end

  assign is_rw      = (cmd == CmdRead) || (cmd == CmdWrite);
  assign sel_active = (bank_eff[s_banksel] == BankActive);
  assign access_ok  = is_rw && sel_active;
  assign rd_en      = access_ok && (cmd == CmdRead);
  assign wr_en      = access_ok && (cmd == CmdWrite);
  assign mode_ok    = (s_addr[2:0] == 3'b000) && (s_addr[6:4] inside {3'd2, 3'd3});
  // Rows above the store size alias onto the low row bits
  assign mem_addr   = {s_banksel, (MEM_AW-2)'({row_q[s_banksel], s_addr[8:0]})};

  always_comb begin
    code_now = ErrNone;
    if ((is_rw || cmd == CmdAct) && init_q != InitReady) begin
      code_now = ErrPreInit;
    end else if (access_ok && tmr_q[s_banksel] < TRcd) begin
      code_now = ErrTrcd;
    end else if (cmd == CmdAct && bank_eff[s_banksel] == BankPrechg) begin
      code_now = ErrTrp;
    end else if (cmd == CmdAct && sel_active) begin
      code_now = ErrActOpen;
    end else if (is_rw && !sel_active) begin
      code_now = ErrNotOpen;
    end else if (cmd != CmdNop && (rc_q < TRc || mrd_q < TMrd)) begin
      code_now = ErrTrcMrd;
    end else if (init_q == InitReady && ref_age_q > TRefMax) begin
      code_now = ErrRefLate;
    end else if (cmd == CmdMrs && !mode_ok) begin
      code_now = ErrMode;
    end else if ((cmd == CmdRef || cmd == CmdMrs) && !all_idle) begin
      code_now = ErrNotIdle;
    end
    err_d  = err_q;
    code_d = code_q;
    if (!err_q && code_now != ErrNone) begin
      err_d  = 1'b1;
      code_d = code_now;
    end
  end

  // Auto-precharge loads 0 so the tRP count starts one edge after the access
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bank_d[b] = bank_eff[b];
      row_d[b]  = row_q[b];
      tmr_d[b]  = sat_inc8(tmr_q[b]);
      if (cmd == CmdAct && s_banksel == 2'(b)) begin
        bank_d[b] = BankActive;
        row_d[b]  = s_addr;
        tmr_d[b]  = 8'd1;
      end else if (cmd == CmdPre && (s_addr[10] || s_banksel == 2'(b)) &&
                   bank_eff[b] == BankActive) begin
        bank_d[b] = BankPrechg;
        tmr_d[b]  = 8'd1;
      end else if (access_ok && s_addr[10] && s_banksel == 2'(b)) begin
        bank_d[b] = BankPrechg;
        tmr_d[b]  = 8'd0;
      end
    end
  end

  always_comb begin
    init_d      = init_q;
    init_refs_d = init_refs_q;
    unique case (init_q)
      InitWaitPre: if (cmd == CmdPre && s_addr[10]) begin
        init_d      = InitWaitRef;
        init_refs_d = 8'd0;
      end
      InitWaitRef: if (cmd == CmdRef) begin
        init_refs_d = sat_inc8(init_refs_q);
        if (init_refs_q + 8'd1 >= InitRefs) init_d = InitWaitMrs;
      end
      InitWaitMrs: if (cmd == CmdMrs && mode_ok) init_d = InitReady;
      default: ;
    endcase
  end

  always_comb begin
    cl3_d     = (cmd == CmdMrs && mode_ok) ? s_addr[4] : cl3_q;
    rc_d      = (cmd == CmdRef) ? 8'd1 : sat_inc8(rc_q);
    mrd_d     = (cmd == CmdMrs) ? 8'd1 : sat_inc8(mrd_q);
    ref_age_d = ref_age_q;
    if (init_q != InitReady && init_d == InitReady) begin
      ref_age_d = 16'd1;
    end else if (init_q == InitReady) begin
      ref_age_d = (cmd == CmdRef) ? 16'd1 : sat_inc16(ref_age_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        bank_q[b] <= BankIdle;
        row_q[b]  <= '0;
        tmr_q[b]  <= 8'hFF;
      end
      init_q         <= InitWaitPre;
      init_refs_q    <= '0;
      cl3_q          <= 1'b0;
      rc_q           <= 8'hFF;
      mrd_q          <= 8'hFF;
      ref_age_q      <= 16'hFFFF;
      err_q          <= 1'b0;
      code_q         <= ErrNone;
      rd_oe_q        <= '0;
      pipe_data_q[0] <= '0;
      pipe_data_q[1] <= '0;
      pipe_oe_q[0]   <= '0;
      pipe_oe_q[1]   <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        bank_q[b] <= bank_d[b];
        row_q[b]  <= row_d[b];
        tmr_q[b]  <= tmr_d[b];
      end
      init_q         <= init_d;
      init_refs_q    <= init_refs_d;
      cl3_q          <= cl3_d;
      rc_q           <= rc_d;
      mrd_q          <= mrd_d;
      ref_age_q      <= ref_age_d;
      err_q          <= err_d;
      code_q         <= code_d;
      rd_oe_q        <= rd_en ? ~s_bytesel : 2'b00;
      pipe_data_q[0] <= mem_rdata;
      pipe_data_q[1] <= pipe_data_q[0];
      pipe_oe_q[0]   <= rd_oe_q;
      pipe_oe_q[1]   <= pipe_oe_q[0];
    end
  end

  sdram_resp_mem #(
    .Aw (MEM_AW)
  ) u_mem (
    .clk_i   (clk),
    .addr_i  (mem_addr),
    .we_i    (wr_en),
    .be_i    (~s_bytesel),
    .wdata_i (s_dq_in),
    .re_i    (rd_en),
    .rdata_o (mem_rdata)
  );

  assign out_data  = cl3_q ? pipe_data_q[1] : pipe_data_q[0];
  assign out_oe    = cl3_q ? pipe_oe_q[1] : pipe_oe_q[0];
  assign s_dq_out  = (out_oe != 2'b00) ? out_data : 16'h0000;
  assign s_dq_oe   = out_oe;
  assign init_done = (init_q == InitReady);
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_sdram_device_responder.sv
// Self-checking bench: scenario tasks plus a read-data scoreboard checked every cycle.
module tb_sdram_device_responder;

  localparam logic [3:0] C_NOP = 4'b0111, C_READ = 4'b0101, C_WRITE = 4'b0100;
  localparam logic [3:0] C_ACT = 4'b0011, C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n, s_cs_n, s_ras_n, s_cas_n, s_wr_en, s_clken;
  logic [1:0]  s_bytesel, s_banksel, s_dq_oe;
  logic [12:0] s_addr;
  logic [15:0] s_dq_in, s_dq_out;
  logic        init_done, err;
  logic [3:0]  err_code;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  oe;
    int          due;
  } rd_t;

  rd_t         exp_q[$];
  logic [15:0] model [int];
  int          total = 0, bad = 0, edge_cnt = 0, cl = 2;
  bit          mon_en = 0;

  sdram_device_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_cs_n    (s_cs_n),
    .s_ras_n   (s_ras_n),
    .s_cas_n   (s_cas_n),
    .s_wr_en   (s_wr_en),
    .s_clken   (s_clken),
    .s_bytesel (s_bytesel),
    .s_addr    (s_addr),
    .s_banksel (s_banksel),
    .s_dq_in   (s_dq_in),
    .s_dq_out  (s_dq_out),
    .s_dq_oe   (s_dq_oe),
    .init_done (init_done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // Read data is due in the sample window after edge READ+CL-1; oe must be low otherwise
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        if (s_dq_oe !== exp_q[0].oe || (exp_q[0].oe != 2'b00 && s_dq_out !== exp_q[0].data)) begin
          bad++;
          $display("FAIL rd_data: got oe=%b dq=%h want oe=%b dq=%h", s_dq_oe, s_dq_out,
                   exp_q[0].oe, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end else if (s_dq_oe !== 2'b00) begin
        bad++;
        $display("FAIL rd_idle_oe: got oe=%b want 00 at edge %0d", s_dq_oe, edge_cnt);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic nop(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] d, input logic [1:0] dqm);
    {s_cs_n, s_ras_n, s_cas_n, s_wr_en} = c;
    s_banksel = ba;
    s_addr    = a;
    s_dq_in   = d;
    s_bytesel = dqm;
    @(negedge clk);
    {s_cs_n, s_ras_n, s_cas_n, s_wr_en} = C_NOP;
    s_bytesel = 2'b11;
  endtask

  function automatic int key(input logic [1:0] ba, input logic [12:0] row, input logic [8:0] col);
    return int'({ba, row, col});
  endfunction

  task automatic wr(input logic [1:0] ba, input logic [12:0] row, input logic [12:0] a,
                    input logic [15:0] d, input logic [1:0] dqm);
    logic [15:0] old;
    int k;
    k   = key(ba, row, a[8:0]);
    old = model.exists(k) ? model[k] : 16'h0000;
    if (!dqm[0]) old[7:0] = d[7:0];
    if (!dqm[1]) old[15:8] = d[15:8];
    model[k] = old;
    issue(C_WRITE, ba, a, d, dqm);
  endtask

  task automatic rd(input logic [1:0] ba, input logic [12:0] row, input logic [12:0] a,
                    input logic [1:0] dqm);
    rd_t e;
    issue(C_READ, ba, a, 16'h0, dqm);
    e.data = model[key(ba, row, a[8:0])];
    e.oe   = ~dqm;
    e.due  = edge_cnt + cl - 1;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nop(2);
    rst_n = 1'b1;
    exp_q.delete();
    cl = 2;
  endtask

  // Returns right after the MRS edge
  task automatic do_init();
    issue(C_PRE, 2'd0, 13'h0400, 16'h0, 2'b11);
    nop(1);
    issue(C_REF, 2'd0, 13'h0, 16'h0, 2'b11);
    nop(7);
    issue(C_REF, 2'd0, 13'h0, 16'h0, 2'b11);
    nop(7);
    issue(C_MRS, 2'd0, 13'h0220, 16'h0, 2'b11);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    nop(2);
    mon_en = 1;
    total += 4;
    if (init_done !== 1'b0) begin bad++; $display("FAIL rst_init: got %b want 0", init_done); end
    if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    if (err_code !== 4'd0) begin bad++; $display("FAIL rst_code: got %0d want 0", err_code); end
    if (s_dq_out !== 16'h0) begin bad++; $display("FAIL rst_dq: got %h want 0", s_dq_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    issue(C_PRE, 2'd0, 13'h0400, 16'h0, 2'b11);
    nop(1);
    issue(C_REF, 2'd0, 13'h0, 16'h0, 2'b11);
    nop(7);
    issue(C_REF, 2'd0, 13'h0, 16'h0, 2'b11);
    nop(7);
    total++;
    if (init_done !== 1'b0) begin bad++; $display("FAIL init_pre_mrs: got %b want 0", init_done); end
    issue(C_MRS, 2'd0, 13'h0220, 16'h0, 2'b11);
    nop(2);
    total += 2;
    if (init_done !== 1'b1) begin bad++; $display("FAIL init_done: got %b want 1", init_done); end
    if (err !== 1'b0) begin bad++; $display("FAIL init_err: got %b want 0", err); end
  endtask

  task automatic test_write_read();
    issue(C_ACT, 2'd1, 13'd5, 16'h0, 2'b11);
    nop(1);
    wr(2'd1, 13'd5, 13'h0403, 16'hA55A, 2'b00);
    nop(2);
    issue(C_ACT, 2'd1, 13'd5, 16'h0, 2'b11);
    nop(1);
    rd(2'd1, 13'd5, 13'h0003, 2'b00);
    nop(3);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL wr_rd_err: got %b code %0d want 0", err, err_code); end
  endtask

  task automatic test_byte_mask();
    wr(2'd1, 13'd5, 13'h0007, 16'hFFFF, 2'b00);
    wr(2'd1, 13'd5, 13'h0007, 16'h1234, 2'b01);
    rd(2'd1, 13'd5, 13'h0007, 2'b00);
    rd(2'd1, 13'd5, 13'h0007, 2'b10);
    nop(4);
    issue(C_PRE, 2'd1, 13'h0000, 16'h0, 2'b11);
    nop(2);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL mask_err: got %b code %0d want 0", err, err_code); end
  endtask

  task automatic test_error_codes();
    int codes [8] = '{1, 2, 3, 4, 5, 6, 8, 9};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (codes[i] != 1) begin
        do_init();
        nop(2);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err%0d_clean: got %b want 0", codes[i], err); end
      end else begin
        nop(2);
      end
      case (codes[i])
        1: issue(C_ACT, 2'd0, 13'd0, 16'h0, 2'b11);
        2: begin
          issue(C_ACT, 2'd2, 13'd9, 16'h0, 2'b11);
          issue(C_READ, 2'd2, 13'h0000, 16'h0, 2'b11);
          nop(1);
          issue(C_ACT, 2'd2, 13'd9, 16'h0, 2'b11);
        end
        3: begin
          issue(C_ACT, 2'd0, 13'd0, 16'h0, 2'b11);
          nop(1);
          issue(C_PRE, 2'd0, 13'h0000, 16'h0, 2'b11);
          issue(C_ACT, 2'd0, 13'd0, 16'h0, 2'b11);
        end
        4: begin
          issue(C_ACT, 2'd0, 13'd0, 16'h0, 2'b11);
          nop(1);
          issue(C_ACT, 2'd0, 13'd1, 16'h0, 2'b11);
        end
        5: issue(C_READ, 2'd3, 13'h0000, 16'h0, 2'b11);
        6: begin
          issue(C_REF, 2'd0, 13'h0, 16'h0, 2'b11);
          issue(C_ACT, 2'd0, 13'd0, 16'h0, 2'b11);
        end
        8: issue(C_MRS, 2'd0, 13'h0021, 16'h0, 2'b11);
        default: begin
          issue(C_ACT, 2'd0, 13'd0, 16'h0, 2'b11);
          nop(1);
          issue(C_REF, 2'd0, 13'h0, 16'h0, 2'b11);
        end
      endcase
      nop(1);
      total++;
      if (err !== 1'b1 || err_code !== 4'(codes[i])) begin
        bad++;
        $display("FAIL err_code%0d: got err=%b code=%0d want err=1 code=%0d", codes[i], err,
                 err_code, codes[i]);
      end
    end
  endtask

  task automatic test_refresh();
    do_reset();
    do_init();
    nop(389);
    issue(C_REF, 2'd0, 13'h0, 16'h0, 2'b11);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ref_at_390: got %b want 0", err); end
    nop(390);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ref_age_390: got %b want 0", err); end
    nop(1);
    total++;
    if (err !== 1'b1 || err_code !== 4'd7) begin
      bad++;
      $display("FAIL ref_late: got err=%b code=%0d want err=1 code=7", err, err_code);
    end
  endtask

  task automatic test_cl3_and_reset();
    do_reset();
    do_init();
    nop(2);
    issue(C_MRS, 2'd0, 13'h0030, 16'h0, 2'b11);
    cl = 3;
    nop(2);
    issue(C_ACT, 2'd2, 13'd3, 16'h0, 2'b11);
    nop(1);
    wr(2'd2, 13'd3, 13'h0001, 16'hBEEF, 2'b00);
    rd(2'd2, 13'd3, 13'h0001, 2'b00);
    nop(4);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL cl3_err: got %b want 0", err); end
    issue(C_READ, 2'd3, 13'h0000, 16'h0, 2'b11);
    issue(C_READ, 2'd2, 13'h0001, 16'h0, 2'b00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cl = 2;
    total += 3;
    if (s_dq_oe !== 2'b00) begin bad++; $display("FAIL midrd_oe: got %b want 00", s_dq_oe); end
    if (err !== 1'b0) begin bad++; $display("FAIL midrd_err: got %b want 0", err); end
    if (err_code !== 4'd0) begin bad++; $display("FAIL midrd_code: got %0d want 0", err_code); end
    nop(3);
  endtask

  initial begin
    rst_n = 1'b0;
    s_clken = 1'b1;
    {s_cs_n, s_ras_n, s_cas_n, s_wr_en} = C_NOP;
    s_bytesel = 2'b11;
    s_banksel = 2'd0;
    s_addr    = 13'h0;
    s_dq_in   = 16'h0;
    @(negedge clk);
    test_reset();
    test_init();
    test_write_read();
    test_byte_mask();
    test_error_codes();
    test_refresh();
    test_cl3_and_reset();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rd_pending: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
